// File: rtl/tt_sel_driver_pkg.sv
// Shared definitions for the design-select pin driver: FSM state encoding and
// default geometry constants, also reused by bench-side tt_ctrl models.
package tt_sel_driver_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int N_UM_DEF   = 384;
  localparam int DIV_DEF    = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST_LO = 3'd1,
    S_RST_HI = 3'd2,
    S_INC_HI = 3'd3,
    S_INC_LO = 3'd4,
    S_ENA    = 3'd5
  } sel_state_e;

  // IDLE and ENA both accept requests; every other state is mid-sequence.
  function automatic logic is_busy(input sel_state_e s);
    return !((s == S_IDLE) || (s == S_ENA));
  endfunction

endpackage

// File: rtl/tt_sel_phase_tmr.sv
// Loadable down-counter timing one pulse phase: load starts a DIV-cycle phase
// and expire is high during its last cycle, so the FSM transitions on time.
module tt_sel_phase_tmr #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int CNT_W = $clog2(DIV + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(DIV);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/tt_sel_driver.sv
// Drives sel_rst_n / sel_inc / ena so that tt_ctrl selects the requested user
// module: disable, reset the select counter, pulse increment addr times, enable.
module tt_sel_driver
  import tt_sel_driver_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_UM   = N_UM_DEF,
  parameter int DIV    = DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  sel_state_e        state_q, state_nxt;
  logic [ADDR_W-1:0] inc_cnt_q, inc_cnt_nxt;
  logic              err_nxt;
  logic              accept;
  logic              addr_ok;
  logic              tmr_load;
  logic              tmr_expire;
  logic [31:0]       addr_ext;

  assign req_ready = !is_busy(state_q);
  assign busy      = is_busy(state_q);
  assign done      = (state_q == S_ENA);
  assign accept    = req_valid && req_ready;
  assign addr_ext  = 32'(req_addr);
  assign addr_ok   = (addr_ext < 32'(N_UM));

  tt_sel_phase_tmr #(
    .DIV (DIV)
  ) u_phase_tmr (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .expire (tmr_expire)
  );

  always_comb begin
    state_nxt   = state_q;
    inc_cnt_nxt = inc_cnt_q;
    err_nxt     = 1'b0;
    case (state_q)
      S_IDLE, S_ENA: begin
        state_nxt = S_IDLE;
        if (accept) begin
          if (addr_ok) begin
            state_nxt   = S_RST_LO;
            inc_cnt_nxt = req_addr;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_RST_LO: if (tmr_expire) state_nxt = S_RST_HI;
      S_RST_HI: if (tmr_expire) state_nxt = (inc_cnt_q == '0) ? S_ENA : S_INC_HI;
      S_INC_HI: if (tmr_expire) state_nxt = S_INC_LO;
      S_INC_LO: begin
        if (tmr_expire) begin
          inc_cnt_nxt = inc_cnt_q - ADDR_W'(1);
          state_nxt   = (inc_cnt_q == ADDR_W'(1)) ? S_ENA : S_INC_HI;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Every entry into a timed state restarts the phase timer.
  assign tmr_load = (state_nxt != state_q) && is_busy(state_nxt);

  // Pads are registered decodes of the next state; ena holds through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      inc_cnt_q      <= '0;
      err            <= 1'b0;
      ctrl_sel_rst_n <= 1'b1;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      inc_cnt_q      <= inc_cnt_nxt;
      err            <= err_nxt;
      ctrl_sel_rst_n <= (state_nxt != S_RST_LO);
      ctrl_sel_inc   <= (state_nxt == S_INC_HI);
      ctrl_ena       <= (state_nxt == S_ENA) || ((state_nxt == S_IDLE) && ctrl_ena);
    end
  end

endmodule

// File: tb/tb_tt_sel_driver.sv
// Bench for tt_sel_driver: three instances (DIV = 2, 1, 3) with a shared
// scoreboard; expected done/err events are queued at request time.
module tb_tt_sel_driver;

  typedef struct {
    bit is_err;
    int cyc;
    int incs;
    bit ena;
  } exp_t;

  logic       clk;
  logic [2:0] rst;
  logic [2:0] req_valid;
  logic [9:0] req_addr [3];
  logic [2:0] req_ready, busy, done, err, sel_rst_n, sel_inc, ena;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [3][$];
  bit   exp_ena [3];

  int   incs [3];
  int   run [3];
  bit   bad [3];
  bit   prev_rst_n [3];
  bit   prev_inc [3];

  function automatic int div_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tt_sel_driver #(
      .ADDR_W (10),
      .N_UM   (384),
      .DIV    ((g == 0) ? 2 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk            (clk),
      .rst            (rst[g]),
      .req_valid      (req_valid[g]),
      .req_addr       (req_addr[g]),
      .req_ready      (req_ready[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .err            (err[g]),
      .ctrl_sel_rst_n (sel_rst_n[g]),
      .ctrl_sel_inc   (sel_inc[g]),
      .ctrl_ena       (ena[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input int g, input int addr, output int acc);
    int n;
    n = 0;
    req_addr[g]  = 10'(addr);
    req_valid[g] = 1'b1;
    while (!req_ready[g] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept_wait%0d", g), 32'(req_ready[g]), 1);
    acc = cyc + 1;
    if (addr >= 384) begin
      sb[g].push_back('{1'b1, acc, 0, exp_ena[g]});
    end else begin
      sb[g].push_back('{1'b0, acc + 2 * div_of(g) * (addr + 1), addr, 1'b1});
      exp_ena[g] = 1'b1;
    end
    @(negedge clk);
    req_valid[g] = 1'b0;
    if (addr < 384) begin
      chk($sformatf("ena_drop%0d", g), 32'(ena[g]), 0);
      chk($sformatf("rst_lo%0d", g), 32'(sel_rst_n[g]), 0);
      chk($sformatf("busy%0d", g), 32'(busy[g]), 1);
    end
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while (sb[g].size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain%0d", g), 32'(sb[g].size()), 0);
  endtask

  // Monitor: tracks inc pulses per sequence and scores done/err events.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (rst[g]) begin
          incs[g] = 0; run[g] = 0; bad[g] = 1'b0;
          prev_rst_n[g] = 1'b1; prev_inc[g] = 1'b0;
          continue;
        end
        if (prev_rst_n[g] && !sel_rst_n[g]) begin
          incs[g] = 0; run[g] = 0; bad[g] = 1'b0;
        end
        if (sel_inc[g] && !prev_inc[g]) incs[g]++;
        if (sel_inc[g]) run[g]++;
        else if (prev_inc[g]) begin
          if (run[g] != div_of(g)) bad[g] = 1'b1;
          run[g] = 0;
        end
        if ((sel_inc[g] && !sel_rst_n[g]) || (ena[g] && (sel_inc[g] || !sel_rst_n[g])))
          bad[g] = 1'b1;
        if (done[g] || err[g]) begin
          chk($sformatf("event_expected%0d", g), 32'(sb[g].size() > 0), 1);
          if (sb[g].size() > 0) begin
            e = sb[g].pop_front();
            chk($sformatf("kind_err%0d", g), 32'(err[g]), 32'(e.is_err));
            chk($sformatf("event_cycle%0d", g), 32'(cyc), 32'(e.cyc));
            if (e.is_err) begin
              chk($sformatf("err_ena%0d", g), 32'(ena[g]), 32'(e.ena));
              chk($sformatf("err_rst_n%0d", g), 32'(sel_rst_n[g]), 1);
              chk($sformatf("err_inc%0d", g), 32'(sel_inc[g]), 0);
              chk($sformatf("err_busy%0d", g), 32'(busy[g]), 0);
            end else begin
              chk($sformatf("inc_count%0d", g), 32'(incs[g]), 32'(e.incs));
              chk($sformatf("pulse_shape%0d", g), 32'(bad[g]), 0);
              chk($sformatf("done_ena%0d", g), 32'(ena[g]), 1);
              chk($sformatf("done_ready%0d", g), 32'(req_ready[g]), 1);
            end
          end
        end
        prev_rst_n[g] = sel_rst_n[g];
        prev_inc[g]   = sel_inc[g];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d errors before stop", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int addrs1 [5] = '{0, 1, 7, 383, 2};
    int addrs2 [4] = '{4, 0, 383, 9};
    rst       = 3'b111;
    req_valid = 3'b000;
    for (int g = 0; g < 3; g++) begin
      req_addr[g] = '0;
      exp_ena[g]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_sel_rst_n", 32'(sel_rst_n[0]), 1);
    chk("rst_sel_inc", 32'(sel_inc[0]), 0);
    chk("rst_ena", 32'(ena[0]), 0);
    chk("rst_ready", 32'(req_ready[0]), 1);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_done", 32'(done[0]), 0);
    chk("rst_err", 32'(err[0]), 0);
    rst = 3'b000;
    @(negedge clk);

    // addr 0: reset pulse only, then enable at T0+4
    send(0, 0, acc);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t1_rst_n_k%0d", k), 32'(sel_rst_n[0]), (k < 2) ? 0 : 1);
      chk($sformatf("t1_inc_k%0d", k), 32'(sel_inc[0]), 0);
    end
    wait_idle(0);

    // out-of-range rejections with ena already high
    send(0, 384, acc);
    wait_idle(0);
    send(0, 1023, acc);
    wait_idle(0);

    // addr 5
    send(0, 5, acc);
    wait_idle(0);

    // request held while busy is ignored, then taken in the done cycle
    send(0, 3, acc);
    req_addr[0]  = 10'd7;
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("t4_ready_busy", 32'(req_ready[0]), 0);
    send(0, 7, acc);
    wait_idle(0);

    // async reset during 4th increment high phase
    send(0, 10, acc);
    repeat (16) @(negedge clk);
    chk("t5_inc_before_rst", 32'(sel_inc[0]), 1);
    #2;
    rst[0] = 1'b1;
    sb[0].delete();
    exp_ena[0] = 1'b0;
    #1;
    chk("t5_inc", 32'(sel_inc[0]), 0);
    chk("t5_ena", 32'(ena[0]), 0);
    chk("t5_rst_n", 32'(sel_rst_n[0]), 1);
    chk("t5_busy", 32'(busy[0]), 0);
    @(negedge clk);
    #1;
    rst[0] = 1'b0;
    @(negedge clk);
    send(0, 2, acc);
    wait_idle(0);

    // back-to-back sequences with DIV=1 and DIV=3
    foreach (addrs1[i]) send(1, addrs1[i], acc);
    wait_idle(1);
    foreach (addrs2[i]) send(2, addrs2[i], acc);
    wait_idle(2);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
